// File: rtl/cv32e40x_clmul_unit.sv
// Iterative carry-less multiplier for the Zbc instructions clmul, clmulh and clmulr.
// Consumes BITS_PER_CYCLE bits of rs2 per cycle, accumulates the 64-bit product and
// returns the selected 32-bit half through a valid/ready handshake.
module cv32e40x_clmul_unit #(
  parameter int unsigned BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  localparam int unsigned N     = 32 / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  if (!(BITS_PER_CYCLE inside {1, 2, 4, 8, 16, 32})) begin : g_bad_bits_per_cycle
    $error("cv32e40x_clmul_unit: BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e             state;
  logic [1:0]         op_q;
  logic [63:0]        a_q;
  logic [31:0]        b_q;
  logic [63:0]        acc_q;
  logic [63:0]        acc_nxt;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               accept;

  // Pick the requested 32-bit window of the 64-bit carry-less product.
  function automatic logic [31:0] select_result(input logic [1:0] op, input logic [63:0] p);
    case (op)
      2'b11:   return p[63:32];
      2'b10:   return p[62:31];
      default: return p[31:0];
    endcase
  endfunction

  assign accept  = (state == IDLE) && valid_i && !kill_i;
  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  // One compute step: XOR the shifted multiplicand in for every set multiplier bit.
  always_comb begin
    acc_nxt = acc_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b_q[i[4:0]]) begin
        acc_nxt = acc_nxt ^ (a_q << i);
      end
    end
    cnt_nxt = cnt_q + CNT_W'(1);
  end

  // Control state, accumulator, step counter and the registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        BUSY: begin
          if (kill_i) begin
            state <= IDLE;
          end else begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_nxt;
            if (cnt_nxt == CNT_W'(N)) begin
              result_o <= select_result(op_q, acc_nxt);
              state    <= DONE;
            end
          end
        end
        DONE: begin
          // A kill and a downstream accept both return to IDLE; the result is simply dropped.
          if (kill_i || ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand shift registers: loaded on accept, so later operand changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op_i;
      a_q  <= {32'b0, op_a_i};
      b_q  <= op_b_i;
    end else if (state == BUSY) begin
      a_q <= a_q << BITS_PER_CYCLE;
      b_q <= b_q >> BITS_PER_CYCLE;
    end
  end

endmodule

// File: tb/tb_cv32e40x_clmul_unit.sv
// Scoreboard bench for cv32e40x_clmul_unit: three instances (4, 1 and 32 bits per cycle),
// directed operations pushed into per-instance queues, monitors compare result and latency.
module tb_cv32e40x_clmul_unit;

  localparam logic [1:0] OP_CLMUL  = 2'b01;
  localparam logic [1:0] OP_CLMULH = 2'b11;
  localparam logic [1:0] OP_CLMULR = 2'b10;

  typedef struct {
    logic [31:0] res;
    int          t;
    int          lat;
    string       tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        v4, v1, v32;
  logic        k4;
  logic        r4, r1, r32;
  logic        rdy4, rdy1, rdy32;
  logic        vo4, vo1, vo32;
  logic [31:0] res4, res1, res32;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int seen4 = 0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q32[$];
  exp_t e4, e1, e32;
  logic pv4 = 1'b0, pv1 = 1'b0, pv32 = 1'b0;

  cv32e40x_clmul_unit #(.BITS_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .valid_i(v4), .ready_o(rdy4), .op_i(op), .op_a_i(a),
    .op_b_i(b), .kill_i(k4), .valid_o(vo4), .ready_i(r4), .result_o(res4));

  cv32e40x_clmul_unit #(.BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .valid_i(v1), .ready_o(rdy1), .op_i(op), .op_a_i(a),
    .op_b_i(b), .kill_i(1'b0), .valid_o(vo1), .ready_i(r1), .result_o(res1));

  cv32e40x_clmul_unit #(.BITS_PER_CYCLE(32)) u32 (
    .clk(clk), .rst_n(rst_n), .valid_i(v32), .ready_o(rdy32), .op_i(op), .op_a_i(a),
    .op_b_i(b), .kill_i(1'b0), .valid_o(vo32), .ready_i(r32), .result_o(res32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: unexpected result 0x%08h, expected no output", name, act);
  endtask

  // Monitors: on each rising valid_o, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (vo4) seen4 <= seen4 + 1;
    if (vo4 && !pv4) begin
      if (q4.size() == 0) unexpected("u4 output", res4);
      else begin
        e4 = q4.pop_front();
        chk({"u4 ", e4.tag}, res4, e4.res);
        chk({"u4 latency ", e4.tag}, 32'(cyc - e4.t), 32'(e4.lat));
      end
    end
    pv4 <= vo4;
  end

  always @(negedge clk) begin
    if (vo1 && !pv1) begin
      if (q1.size() == 0) unexpected("u1 output", res1);
      else begin
        e1 = q1.pop_front();
        chk({"u1 ", e1.tag}, res1, e1.res);
        chk({"u1 latency ", e1.tag}, 32'(cyc - e1.t), 32'(e1.lat));
      end
    end
    pv1 <= vo1;
  end

  always @(negedge clk) begin
    if (vo32 && !pv32) begin
      if (q32.size() == 0) unexpected("u32 output", res32);
      else begin
        e32 = q32.pop_front();
        chk({"u32 ", e32.tag}, res32, e32.res);
        chk({"u32 latency ", e32.tag}, 32'(cyc - e32.t), 32'(e32.lat));
      end
    end
    pv32 <= vo32;
  end

  // Present a one-cycle request to the selected instances; operands are scrambled afterwards.
  task automatic issue(input bit d4, input bit d1, input bit d32, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y, input logic [31:0] res,
                       input bit expect_out, input string tag);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y;
    v4 = d4; v1 = d1; v32 = d32;
    e.res = res; e.t = cyc; e.tag = tag;
    if (expect_out) begin
      if (d4)  begin e.lat = 9;  q4.push_back(e);  end
      if (d1)  begin e.lat = 33; q1.push_back(e);  end
      if (d32) begin e.lat = 2;  q32.push_back(e); end
    end
    @(negedge clk);
    v4 = 1'b0; v1 = 1'b0; v32 = 1'b0;
    op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(rdy4 && rdy1 && rdy32 && !vo4 && !vo1 && !vo32) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({"idle timeout ", tag}, 32'(n >= budget), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q4.delete(); q1.delete(); q32.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b1;
    op = 2'b00; a = '0; b = '0;
    v4 = 0; v1 = 0; v32 = 0; k4 = 0;
    r4 = 1; r1 = 1; r32 = 1;
    #3 rst_n = 1'b0;
    #1;
    chk("reset ready_o", {31'b0, rdy4}, 32'd1);
    chk("reset valid_o", {31'b0, vo4}, 32'd0);
    chk("reset result_o", res4, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Small operands, each op after its own reset
    issue(1, 0, 0, OP_CLMUL,  32'h3, 32'h3, 32'h5, 1, "clmul 3x3");
    wait_idle(20, "clmul 3x3");
    do_reset();
    issue(1, 0, 0, OP_CLMULH, 32'h3, 32'h3, 32'h0, 1, "clmulh 3x3");
    wait_idle(20, "clmulh 3x3");
    do_reset();
    issue(1, 0, 0, OP_CLMULR, 32'h3, 32'h3, 32'h0, 1, "clmulr 3x3");
    wait_idle(20, "clmulr 3x3");

    // Top and bottom bits: (x^31+1)^2 = x^62+1
    issue(1, 0, 0, OP_CLMUL,  32'h8000_0001, 32'h8000_0001, 32'h0000_0001, 1, "clmul msb");
    wait_idle(20, "clmul msb");
    issue(1, 0, 0, OP_CLMULH, 32'h8000_0001, 32'h8000_0001, 32'h4000_0000, 1, "clmulh msb");
    wait_idle(20, "clmulh msb");
    issue(1, 0, 0, OP_CLMULR, 32'h8000_0001, 32'h8000_0001, 32'h8000_0000, 1, "clmulr msb");
    wait_idle(20, "clmulr msb");

    // All ones on every bits-per-cycle variant
    issue(1, 1, 1, OP_CLMUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1, "clmul ones");
    wait_idle(60, "clmul ones");
    issue(1, 1, 1, OP_CLMULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 1, "clmulh ones");
    wait_idle(60, "clmulh ones");
    issue(1, 1, 1, OP_CLMULR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1, "clmulr ones");
    wait_idle(60, "clmulr ones");
    issue(1, 1, 1, 2'b00,     32'h0000_0007, 32'h0000_0005, 32'h0000_001B, 1, "reserved op");
    wait_idle(60, "reserved op");

    // Back-pressure: hold the result for 5 cycles
    r4 = 1'b0;
    issue(1, 0, 0, OP_CLMULR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1, "backpressure");
    n = 0;
    while (!vo4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("backpressure valid timeout", 32'(n >= 20), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("backpressure valid_o", {31'b0, vo4}, 32'd1);
      chk("backpressure result_o", res4, 32'hAAAA_AAAA);
      chk("backpressure ready_o", {31'b0, rdy4}, 32'd0);
    end
    r4 = 1'b1;
    @(posedge clk);
    #1;
    chk("release valid_o", {31'b0, vo4}, 32'd0);
    chk("release ready_o", {31'b0, rdy4}, 32'd1);

    // Kill in the third BUSY cycle
    @(negedge clk);
    seen4 = 0;
    issue(1, 0, 0, OP_CLMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, "killed");
    @(negedge clk);
    @(negedge clk);
    k4 = 1'b1;
    @(posedge clk);
    #1;
    chk("kill ready_o", {31'b0, rdy4}, 32'd1);
    chk("kill valid_o", {31'b0, vo4}, 32'd0);
    @(negedge clk);
    k4 = 1'b0;
    repeat (12) @(negedge clk);
    chk("kill no output", 32'(seen4), 32'd0);
    issue(1, 0, 0, OP_CLMUL, 32'h3, 32'h3, 32'h5, 1, "after kill");
    wait_idle(20, "after kill");

    // Kill together with a request in IDLE
    @(negedge clk);
    op = OP_CLMUL; a = 32'h3; b = 32'h3;
    v4 = 1'b1; k4 = 1'b1;
    @(posedge clk);
    #1;
    chk("kill in idle ready_o", {31'b0, rdy4}, 32'd1);
    @(negedge clk);
    v4 = 1'b0; k4 = 1'b0;
    repeat (12) @(negedge clk);
    issue(1, 0, 0, OP_CLMULH, 32'h8000_0001, 32'h8000_0001, 32'h4000_0000, 1, "post idle kill");
    wait_idle(20, "post idle kill");

    // Asynchronous reset mid-BUSY
    issue(1, 0, 0, OP_CLMUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, "reset drop");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid_o", {31'b0, vo4}, 32'd0);
    chk("async reset result_o", res4, 32'd0);
    chk("async reset ready_o", {31'b0, rdy4}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1, 0, 0, OP_CLMUL, 32'h3, 32'h3, 32'h5, 1, "after reset");
    wait_idle(20, "after reset");

    repeat (3) @(negedge clk);
    chk("u4 queue drained", 32'(q4.size()), 32'd0);
    chk("u1 queue drained", 32'(q1.size()), 32'd0);
    chk("u32 queue drained", 32'(q32.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cv32e40x_clmul_unit.md
Name: cv32e40x_clmul_unit

Overview:
Iterative carry-less multiplier for the RV32 Zbc instructions clmul, clmulh and clmulr. It sits in EX alongside the ALU, directly downstream of the B-extension decode path, and consumes the Zbc operation and the two register operands.
It computes the full 64-bit carry-less product over several cycles and returns one 32-bit result through a valid/ready handshake to the EX/WB path.

Parameters:
BITS_PER_CYCLE, 4, multiplier bits of operand B consumed per compute cycle; legal values 1, 2, 4, 8, 16, 32; any other value is an elaboration error.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
valid_i  input  1  operation request from EX
ready_o  output  1  unit can accept an operation this cycle
op_i  input  2  01=CLMUL, 11=CLMULH, 10=CLMULR, 00=reserved (executes as CLMUL)
op_a_i  input  32  rs1 value
op_b_i  input  32  rs2 value
kill_i  input  1  abort current operation (flush/exception)
valid_o  output  1  result available
ready_i  input  1  downstream accepts result
result_o  output  32  result

Behaviour:
- Reset: state=IDLE, valid_o=0, result_o=0, ready_o=1, internal accumulator/counter=0. Reset mid-operation drops the operation with no output.
- Clocking: single clock; all state updates on the rising edge of clk.
- Let N = 32/BITS_PER_CYCLE.
- State machine:
  - IDLE: ready_o=1. On valid_i && !kill_i, latch op, A zero-extended to 64 bits, B, clear the 64-bit accumulator and counter, and go to BUSY.
  - BUSY: ready_o=0. Each cycle, for each of the BITS_PER_CYCLE lowest bits of the B shift register, XOR (A << bit) into the accumulator. Then shift A left by BITS_PER_CYCLE, shift B right by BITS_PER_CYCLE, and increment the counter. After the Nth compute cycle, register result_o and go to DONE.
  - DONE: valid_o=1, ready_o=0. result_o and valid_o stay stable until ready_i. When ready_i is high, go to IDLE next cycle; no back-to-back accept in the same cycle.
- Latency: request accepted in cycle t, compute in cycles t+1..t+N, valid_o first high in cycle t+N+1. Default N=8.
- Result selection (P = 64-bit carry-less product):
  - CLMUL: P[31:0]
  - CLMULH: P[63:32]
  - CLMULR: P[62:31]
- Arithmetic: XOR only, no carries. A shifted out beyond bit 63 is discarded. The counter width is sized for N and does not wrap before it reaches N.
- kill_i:
  - In BUSY or DONE: go to IDLE next cycle and deassert valid_o; the result is discarded.
  - In IDLE together with valid_i: the request is not accepted.
  - kill_i has priority over ready_i in DONE.
- ready_o depends only on state, never combinationally on valid_i.
- valid_o depends only on state.
- Operand changes on op_a_i/op_b_i/op_i after acceptance have no effect.

Test Plan:
- Three separate operations, each reset -> IDLE, with valid_i for one cycle and ready_i=1:
  - op=CLMUL, a=0x0000_0003, b=0x0000_0003 -> result_o=0x0000_0005.
  - op=CLMULH with the same operands -> 0x0000_0000.
  - op=CLMULR with the same operands -> 0x0000_0000.
- a=0x8000_0001, b=0x8000_0001 -> CLMUL=0x0000_0001, CLMULH=0x4000_0000, CLMULR=0x8000_0000. Check that valid_o rises exactly 9 cycles after the accept edge at the default parameter.
- a=b=0xFFFF_FFFF -> CLMUL=0x5555_5555, CLMULH=0x5555_5555, CLMULR=0xAAAA_AAAA. Repeat with BITS_PER_CYCLE=1 (valid_o at t+33) and BITS_PER_CYCLE=32 (valid_o at t+2) -> identical results.
- Result back-pressure: hold ready_i=0 for 5 cycles in DONE -> valid_o stays 1, result_o stays stable, ready_o stays 0. Raise ready_i -> next cycle valid_o=0 and ready_o=1.
- Kill handling:
  - kill_i pulse in the 3rd BUSY cycle -> IDLE next cycle and valid_o never asserts.
  - A new op then yields a correct result with no residue from the killed op.
  - kill_i together with valid_i in IDLE -> not accepted.
- Reset handling:
  - Deassert rst_n asynchronously mid-BUSY -> valid_o=0, result_o=0, ready_o=1 immediately.
  - After reset release, a CLMUL of 0x3 and 0x3 returns 0x5.
